dmem_responder: RTL and testbench

Data-memory responder for the multicycle MIPS core: it answers the core's data-side requests (`data_addr`, `w_data`, `dmem_w`, `dmem_r`, `store_format_signal`) and drives `dmem_data` back into the core's MDR. It holds a word-organised RAM with byte and half-word write lanes, and returns read data lane-aligned so the addressed byte or half-word sits in bits [7:0] or [15:0]. After reset, a clear state machine zeroes the array; the block also flags misaligned and out-of-range accesses.

---
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-side bus between the multicycle core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic [31:0] data_addr;
  logic [31:0] w_data;
  logic        dmem_w;
  logic        dmem_r;
  logic [1:0]  store_format_signal;
  logic [31:0] dmem_data;
  logic        init_done;
  logic        acc_err;
  logic [31:0] err_addr;

  modport master (
    output data_addr, w_data, dmem_w, dmem_r, store_format_signal,
    input  dmem_data, init_done, acc_err, err_addr
  );

  modport slave (
    input  data_addr, w_data, dmem_w, dmem_r, store_format_signal,
    output dmem_data, init_done, acc_err, err_addr
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with byte/half-word write lanes, lane-aligned registered reads,
// a post-reset clear sequence and misaligned/out-of-range access flagging.
module dmem_responder #(
  parameter int unsigned ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic            clk,
  input  logic            rstn,
  dmem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t             r_state;
  logic [31:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [31:0]        r_dmem_data;
  logic               r_init_done;
  logic               r_acc_err;
  logic [31:0]        r_err_addr;
  logic               r_err_cap;

  logic [31:0]        w_off;
  logic               w_in_range;
  logic [1:0]         w_lane;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_wr_legal;
  logic               w_wr_ok;
  logic               w_reject;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_rd_shift;
  logic               w_we;
  logic [ADDR_W-1:0]  w_widx;
  logic [31:0]        w_wdata;
  logic [3:0]         w_be;

  // A data_addr below the base wraps to a huge offset and so falls out of range.
  assign w_off      = bus.data_addr - BASE_ADDR;
  assign w_in_range = (w_off[31:ADDR_W+2] == '0);
  assign w_lane     = w_off[1:0];
  assign w_idx      = w_off[ADDR_W+1:2];

  always_comb begin
    w_wr_legal = 1'b0;
    case (bus.store_format_signal)
      2'b00:   w_wr_legal = (w_lane == 2'b00);
      2'b01:   w_wr_legal = ~w_lane[0];
      2'b10:   w_wr_legal = 1'b1;
      default: w_wr_legal = 1'b0;
    endcase
  end

  assign w_wr_ok  = (r_state == READY) && bus.dmem_w && w_in_range && w_wr_legal;
  assign w_reject = (r_state == READY) &&
                    ((bus.dmem_w && !(w_in_range && w_wr_legal)) ||
                     (bus.dmem_r && !w_in_range));

  assign w_rd_word  = r_mem[w_idx];
  assign w_rd_shift = w_rd_word >> {w_lane, 3'b000};

  // Single write port shared by the clear sequence and core stores.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_idx;
    w_wdata = bus.w_data;
    w_be    = '0;
    if (r_state == CLEAR) begin
      w_we    = 1'b1;
      w_widx  = r_clr_cnt;
      w_wdata = '0;
      w_be    = '1;
    end else if (w_wr_ok) begin
      w_we = 1'b1;
      case (bus.store_format_signal)
        2'b01: begin
          w_wdata = {2{bus.w_data[15:0]}};
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        end
        2'b10: begin
          w_wdata = {4{bus.w_data[7:0]}};
          w_be    = 4'b0001 << w_lane;
        end
        default: w_be = '1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Reads use the pre-edge array contents, giving read-before-write on a shared cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_dmem_data <= '0;
      r_init_done <= 1'b0;
      r_acc_err   <= 1'b0;
      r_err_addr  <= '0;
      r_err_cap   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_acc_err <= 1'b0;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end
        end
        READY: begin
          r_acc_err <= w_reject;
          if (bus.dmem_r) r_dmem_data <= w_in_range ? w_rd_shift : '0;
          if (w_reject && !r_err_cap) begin
            r_err_addr <= bus.data_addr;
            r_err_cap  <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign bus.dmem_data = r_dmem_data;
  assign bus.init_done = r_init_done;
  assign bus.acc_err   = r_acc_err;
  assign bus.err_addr  = r_err_addr;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: clear timing, table of store/load vectors checked through
// an expected-result queue, and reset-during-operation / reset-during-clear sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(
    .ADDR_W   (11),
    .BASE_ADDR(32'h1001_0000)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        w;
    logic        r;
    logic [1:0]  fmt;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [31:0] eaddr;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic w, input logic r, input logic [1:0] fmt,
                              input logic [31:0] exp_data, input logic exp_err,
                              input logic [31:0] exp_eaddr);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.w = w; v.r = r; v.fmt = fmt;
    v.exp_data = exp_data; v.exp_err = exp_err; v.exp_eaddr = exp_eaddr;
    return v;
  endfunction

  task automatic idle();
    bus.data_addr           = '0;
    bus.w_data              = '0;
    bus.dmem_w              = 1'b0;
    bus.dmem_r              = 1'b0;
    bus.store_format_signal = 2'b00;
  endtask

  // Drive on the falling edge, compare #1 after the rising edge that samples it.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.data_addr           = v.addr;
    bus.w_data              = v.wdata;
    bus.dmem_w              = v.w;
    bus.dmem_r              = v.r;
    bus.store_format_signal = v.fmt;
    e.data = v.exp_data; e.err = v.exp_err; e.eaddr = v.exp_eaddr; e.idx = idx;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check($sformatf("vec%0d dmem_data", got.idx), bus.dmem_data, got.data);
    check($sformatf("vec%0d acc_err", got.idx), {31'b0, bus.acc_err}, {31'b0, got.err});
    check($sformatf("vec%0d err_addr", got.idx), bus.err_addr, got.eaddr);
  endtask

  task automatic count_clear(input string name);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 2100 && !done; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) done = 1'b1;
    end
    check(name, n, 2048);
  endtask

  localparam logic [31:0] EA = 32'h1001_0007;

  initial begin
    bit quiet_ok;

    vecs.push_back(mk(32'h1001_0FFC, 32'h0,        0, 1, 2'b00, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0004, 32'hDEADBEEF, 1, 0, 2'b00, 32'h0000_0000, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0005, 32'h123456AA, 1, 0, 2'b10, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'hDEADAAEF, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0005, 32'h0,        0, 1, 2'b00, 32'h00DEADAA, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0007, 32'h0,        0, 1, 2'b00, 32'h000000DE, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0006, 32'h00001234, 1, 0, 2'b01, 32'h000000DE, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'h1234AAEF, 0, 32'h0));
    vecs.push_back(mk(32'h1001_0007, 32'h0000FFFF, 1, 0, 2'b01, 32'h1234AAEF, 1, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'h1234AAEF, 0, EA));
    vecs.push_back(mk(32'h1001_0002, 32'hCAFEF00D, 1, 0, 2'b00, 32'h1234AAEF, 1, EA));
    vecs.push_back(mk(32'h1001_0000, 32'h0,        0, 1, 2'b00, 32'h0000_0000, 0, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'h1234AAEF, 0, EA));
    vecs.push_back(mk(32'h1001_2000, 32'h0,        0, 1, 2'b00, 32'h0000_0000, 1, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'h1234AAEF, 0, EA));
    vecs.push_back(mk(32'h1000_FFFC, 32'h0,        0, 1, 2'b00, 32'h0000_0000, 1, EA));
    vecs.push_back(mk(32'h0,         32'h0,        0, 0, 2'b00, 32'h0000_0000, 0, EA));
    vecs.push_back(mk(32'h1001_0008, 32'h55555555, 1, 0, 2'b11, 32'h0000_0000, 1, EA));
    vecs.push_back(mk(32'h1001_000B, 32'h00000077, 1, 0, 2'b10, 32'h0000_0000, 0, EA));
    vecs.push_back(mk(32'h1001_0008, 32'h0,        0, 1, 2'b00, 32'h77000000, 0, EA));
    vecs.push_back(mk(32'h1001_000A, 32'h0,        0, 1, 2'b00, 32'h00007700, 0, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h11111111, 1, 1, 2'b00, 32'h1234AAEF, 0, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        0, 1, 2'b00, 32'h11111111, 0, EA));
    vecs.push_back(mk(32'h0,         32'h0,        0, 0, 2'b00, 32'h11111111, 0, EA));
    vecs.push_back(mk(32'h1001_2000, 32'h0,        1, 1, 2'b11, 32'h0000_0000, 1, EA));
    vecs.push_back(mk(32'h0,         32'h0,        0, 0, 2'b00, 32'h0000_0000, 0, EA));
    vecs.push_back(mk(32'h1001_1FFC, 32'hA5A5A5A5, 1, 0, 2'b00, 32'h0000_0000, 0, EA));
    vecs.push_back(mk(32'h1001_1FFC, 32'h0,        0, 1, 2'b00, 32'hA5A5A5A5, 0, EA));
    vecs.push_back(mk(32'h1001_1FFF, 32'h0,        0, 1, 2'b00, 32'h000000A5, 0, EA));
    vecs.push_back(mk(32'h1001_2000, 32'h000000FF, 1, 0, 2'b10, 32'h000000A5, 1, EA));
    vecs.push_back(mk(32'h1001_0004, 32'h0,        1, 1, 2'b11, 32'h11111111, 1, EA));

    idle();
    #12;
    check("reset dmem_data", bus.dmem_data, 32'h0);
    check("reset init_done", {31'b0, bus.init_done}, 32'h0);

    // Clear phase: accesses must be ignored and init_done must rise on edge 2048.
    @(negedge clk);
    rstn = 1'b1;
    quiet_ok = 1'b1;
    for (int i = 1; i <= 2048; i++) begin
      @(posedge clk);
      #1;
      if (bus.acc_err !== 1'b0 || bus.dmem_data !== 32'h0) quiet_ok = 1'b0;
      if (i == 2047) check("init_done before edge 2048", {31'b0, bus.init_done}, 32'h0);
      if (i < 2047 && bus.init_done !== 1'b0) quiet_ok = 1'b0;
      if (i < 2040) begin
        bus.data_addr           = 32'h1000_0000 + $urandom_range(0, 32'h0003_0000);
        bus.w_data              = $urandom;
        bus.dmem_w              = $urandom_range(0, 1);
        bus.dmem_r              = $urandom_range(0, 1);
        bus.store_format_signal = $urandom_range(0, 3);
      end else begin
        idle();
      end
    end
    check("init_done at edge 2048", {31'b0, bus.init_done}, 32'h1);
    check("clear quiet (no data, no err)", {31'b0, quiet_ok}, 32'h1);
    check("err_addr after clear", bus.err_addr, 32'h0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset between edges, while acc_err and dmem_data are non-zero.
    #2;
    rstn = 1'b0;
    #1;
    check("async rst dmem_data", bus.dmem_data, 32'h0);
    check("async rst init_done", {31'b0, bus.init_done}, 32'h0);
    check("async rst acc_err", {31'b0, bus.acc_err}, 32'h0);
    check("async rst err_addr", bus.err_addr, 32'h0);
    @(negedge clk);
    idle();
    rstn = 1'b1;
    count_clear("clear length after mid-op reset");
    apply(mk(32'h1001_0004, 32'h0, 0, 1, 2'b00, 32'h0, 0, 32'h0), 100);
    apply(mk(32'h1001_0008, 32'h0, 0, 1, 2'b00, 32'h0, 0, 32'h0), 101);

    // Reset in the middle of the clear: the count must restart from zero.
    @(negedge clk);
    idle();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("mid-clear rst init_done", {31'b0, bus.init_done}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    count_clear("clear length after mid-clear reset");
    apply(mk(32'h1001_1FFC, 32'h0, 0, 1, 2'b00, 32'h0, 0, 32'h0), 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
